bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 16-bit datapath resource among NUM_REQ requesters. Typical resources are the data-memory port or a Mux16/Mux4Way16 selection tree.
- Produces a registered one-hot grant vector and a binary SEL that drives the mux tree select lines directly.
- A hold counter bounds how long one requester can own the resource while others wait.
- Sits between requesters (CPU memory stage, loader, peripheral DMA) and the shared mux.

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one datapath resource among NUM_REQ requesters.
// Issues a registered one-hot grant, the owner's binary index for the mux
// select lines, and a busy flag. A hold counter bounds how long one owner may
// keep the resource while another requester is waiting.
module bus_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int SEL_WIDTH = 2,
   parameter int MAX_HOLD  = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_REQ-1:0]   REQ,
   output logic [NUM_REQ-1:0]   GNT,
   output logic [SEL_WIDTH-1:0] SEL,
   output logic                 BUSY
);

   localparam int                CNT_W   = 8;
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_HOLD);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   // Result of a round-robin search: whether any bit was found, and where.
   typedef struct packed {
      logic                 found;
      logic [SEL_WIDTH-1:0] idx;
   } pick_t;

   state_t               state_q, state_d;
   logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 busy_q, busy_d;
   pick_t                pick;

   // Index of the requester after g, wrapping at NUM_REQ (which need not be a
   // power of two, so plain overflow of the SEL_WIDTH field is not enough).
   function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] g);
      if (int'(g) == NUM_REQ - 1) return '0;
      return g + 1'b1;
   endfunction

   // First set bit of mask, searching upward from start with wrap-around.
   // The loop runs downward so the lowest distance from start is assigned last.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0]   mask,
                                     input logic [SEL_WIDTH-1:0] start);
      pick_t                p;
      int                   idx;
      logic [SEL_WIDTH-1:0] idx_s;
      p = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(start) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_s = SEL_WIDTH'(idx);
         if (mask[idx_s]) begin
            p.found = 1'b1;
            p.idx   = idx_s;
         end
      end
      return p;
   endfunction

   // Next-state logic: idle arbitration, release handoff, hold-limit preemption.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      pick    = '0;

      unique case (state_q)
         IDLE: begin
            pick = rr_pick(REQ, ptr_q);
         end
         GRANT: begin
            if (!REQ[sel_q]) begin
               // Owner released: hand off on this edge, no bubble cycle.
               pick = rr_pick(REQ, wrap_inc(sel_q));
               if (!pick.found) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  cnt_d   = '0;
               end
            end else if (cnt_q == MAX_CNT) begin
               // Hold limit reached: pass to the next waiting requester if any.
               pick = rr_pick(REQ & ~gnt_q, wrap_inc(sel_q));
               if (!pick.found) cnt_d = CNT_W'(1);
            end else if (cnt_q < MAX_CNT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase

      if (pick.found) begin
         state_d = GRANT;
         gnt_d   = NUM_REQ'(1) << pick.idx;
         sel_d   = pick.idx;
         cnt_d   = CNT_W'(1);
         ptr_d   = wrap_inc(pick.idx);
      end

      busy_d = |gnt_d;
   end

   // State register with synchronous active-high reset; SEL keeps its value in idle.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (RESET) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign GNT  = gnt_q;
   assign SEL  = sel_q;
   assign BUSY = busy_q;

   // Grant is always one-hot or zero.
   a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (RESET) $onehot0(gnt_q));

   // A requester sampled low on an edge is never granted by that edge.
   a_gnt_requested : assert property (@(posedge CLK) disable iff (RESET) ((gnt_d & ~REQ) == '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and randomized requests against a reference model.
module tb_bus_arbiter;

   localparam int N        = 4;
   localparam int SW       = 2;
   localparam int MAX_HOLD = 8;

   logic          CLK;
   logic          RESET;
   logic [N-1:0]  REQ;
   logic [N-1:0]  GNT;
   logic [SW-1:0] SEL;
   logic          BUSY;

   int errors = 0;
   int checks = 0;

   // Reference model state: owner index (-1 when idle), pointer, cycles held.
   int          m_owner;
   int          m_ptr;
   int          m_held;
   logic [SW-1:0] m_sel;

   typedef struct {
      logic          rst;
      logic [N-1:0]  req;
      logic [N-1:0]  gnt;
      logic [SW-1:0] sel;
      logic          busy;
   } vec_t;

   vec_t vecs[12];

   bus_arbiter #(.NUM_REQ(N), .SEL_WIDTH(SW), .MAX_HOLD(MAX_HOLD)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .REQ  (REQ),
      .GNT  (GNT),
      .SEL  (SEL),
      .BUSY (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string name, input logic [N-1:0] gnt,
                            input logic [SW-1:0] sel, input logic busy);
      check({name, ".gnt"}, 32'(GNT), 32'(gnt));
      check({name, ".sel"}, 32'(SEL), 32'(sel));
      check({name, ".busy"}, 32'(BUSY), 32'(busy));
   endtask

   // First set bit of m at or after start, wrapping; -1 if none.
   function automatic int first_from(input logic [N-1:0] m, input int start);
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (start + i) % N;
         if (m[idx]) return idx;
      end
      return -1;
   endfunction

   // Advance the reference model by one rising edge.
   task automatic model_update(input logic rst, input logic [N-1:0] req);
      logic [N-1:0] others;
      int g;
      g = -1;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
         m_sel   = '0;
      end else if (m_owner < 0) begin
         if (req != '0) g = first_from(req, m_ptr);
      end else if (!req[m_owner]) begin
         g = first_from(req, (m_owner + 1) % N);
         if (g < 0) m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
         others = req;
         others[m_owner] = 1'b0;
         g = first_from(others, (m_owner + 1) % N);
         if (g < 0) m_held = 1;
      end else begin
         m_held++;
      end
      if (g >= 0) begin
         m_owner = g;
         m_held  = 1;
         m_ptr   = (g + 1) % N;
         m_sel   = SW'(g);
      end
   endtask

   // Drive inputs, clock one edge, then settle just past the edge for sampling.
   task automatic step(input logic rst, input logic [N-1:0] req);
      RESET = rst;
      REQ   = req;
      model_update(rst, req);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1;
      REQ   = '0;
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = '0;

      // ---------------- directed vector table ----------------
      vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      vecs[5]  = '{1'b0, 4'b0110, 4'b0100, 2'd2, 1'b1};
      vecs[6]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
      vecs[7]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
      vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0};
      vecs[9]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
      vecs[10] = '{1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0};
      vecs[11] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].req);
         check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
      end

      // ---------------- single requester, no drop at hold expiry ----------------
      step(1'b1, 4'b0000);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 4'b0100);
         check_out("single_hold", 4'b0100, 2'd2, 1'b1);
      end
      step(1'b0, 4'b0000);
      check_out("single_drop", 4'b0000, 2'd2, 1'b0);

      // ---------------- round-robin with all requests high ----------------
      step(1'b1, 4'b0000);
      for (int k = 1; k <= 40; k++) begin
         int o;
         o = ((k - 1) / MAX_HOLD) % N;
         step(1'b0, 4'b1111);
         check_out($sformatf("rr_k%0d", k), N'(1 << o), SW'(o), 1'b1);
      end

      // ---------------- early release then hold limit ----------------
      step(1'b1, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 4'b0011);
         check_out("early_own0", 4'b0001, 2'd0, 1'b1);
      end
      step(1'b0, 4'b0010);
      check_out("early_hand1", 4'b0010, 2'd1, 1'b1);
      for (int k = 0; k < MAX_HOLD - 1; k++) begin
         step(1'b0, 4'b0011);
         check_out("early_keep1", 4'b0010, 2'd1, 1'b1);
      end
      step(1'b0, 4'b0011);
      check_out("early_preempt0", 4'b0001, 2'd0, 1'b1);

      // ---------------- pointer wrap ----------------
      step(1'b1, 4'b0000);
      step(1'b0, 4'b0100);
      check_out("wrap_g2", 4'b0100, 2'd2, 1'b1);
      step(1'b0, 4'b0000);
      check_out("wrap_idle", 4'b0000, 2'd2, 1'b0);
      step(1'b0, 4'b1001);
      check_out("wrap_g3", 4'b1000, 2'd3, 1'b1);
      step(1'b0, 4'b0001);
      check_out("wrap_g0", 4'b0001, 2'd0, 1'b1);
      step(1'b0, 4'b0000);
      check_out("wrap_idle2", 4'b0000, 2'd0, 1'b0);
      step(1'b0, 4'b0011);
      check_out("wrap_ptr1", 4'b0010, 2'd1, 1'b1);

      // ---------------- reset mid-grant ----------------
      step(1'b1, 4'b0000);
      for (int k = 0; k < 5; k++) step(1'b0, 4'b0100);
      check_out("midrst_own2", 4'b0100, 2'd2, 1'b1);
      step(1'b1, 4'b0110);
      check_out("midrst_rst", 4'b0000, 2'd0, 1'b0);
      step(1'b0, 4'b0110);
      check_out("midrst_g1", 4'b0010, 2'd1, 1'b1);

      // ---------------- randomized against the reference model ----------------
      begin
         logic [N-1:0] req_v;
         logic         rst_v;
         req_v = '0;
         step(1'b1, req_v);
         for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < N; b++)
               if ($urandom_range(0, 5) == 0) req_v[b] = ~req_v[b];
            rst_v = ($urandom_range(0, 199) == 0);
            step(rst_v, req_v);
            check_out($sformatf("rand%0d", cyc),
                      (m_owner < 0) ? N'(0) : N'(1 << m_owner),
                      m_sel, (m_owner >= 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
